pose_transform_stream: RTL and testbench
========================================

POSE_TRANSFORM_STREAM -- requirements
Module: pose_transform_stream

Interface
REQ-001 Parameters SHALL be: CLOUD_BW, default package CLOUD_BW, signed point width; POSE_BW, default package POSE_BW, signed pose element width; MUL, default package MUL, fractional bits of the rotation elements.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be: i_clk in 1, clock; i_rst in 1, synchronous active-high reset.
REQ-004 Ports SHALL be: i_valid in 1, input point valid; o_ready out 1, input point accepted when i_valid&&o_ready.
REQ-005 Ports SHALL be: i_cloud_x, i_cloud_y, i_cloud_z in CLOUD_BW each, signed input point.
REQ-006 Ports SHALL be: i_pose_valid in 1, load shadow pose; i_pose in POSE_BW x12, row-major 3x4 [R|t].
REQ-007 Ports SHALL be: i_pose_commit in 1, shadow-to-active copy; i_mode in 1, 0=R*p+t, 1=R*p (no translation).
REQ-008 Ports SHALL be: o_valid out 1; i_ready in 1, downstream accept.
REQ-009 Ports SHALL be: o_cloud_x, o_cloud_y, o_cloud_z out CLOUD_BW each, signed result; o_sat out 3, per-axis saturation flag {z,y,x}.

Function
REQ-010 Each output axis SHALL equal sat(sum_j (R[i][j]*p[j] >>> MUL) + t[i]), with t[i] forced to 0 when mode=1.
REQ-011 Products SHALL be full-precision signed CLOUD_BW+POSE_BW bits; each product SHALL be arithmetic-shifted right by MUL (floor) before summation.
REQ-012 The sum SHALL be carried in CLOUD_BW+POSE_BW-MUL+2 bits; t[i] SHALL be sign-extended into that width.
REQ-013 The result SHALL be clamped to [-2^(CLOUD_BW-1), 2^(CLOUD_BW-1)-1]; the matching o_sat bit SHALL be 1 iff clamping occurred.
REQ-014 The pipeline SHALL be 3 stages (mult stage 1, mult stage 2, add/saturate); with i_ready held high, o_valid SHALL rise exactly 3 cycles after acceptance.
REQ-015 All stages SHALL advance together iff the output stage is empty or i_ready=1; o_ready SHALL equal this advance condition.
REQ-016 With i_ready low and o_valid high, o_cloud_*, o_sat and o_valid SHALL hold stable; no point SHALL be dropped or duplicated.
REQ-017 Throughput SHALL be one point per cycle while i_ready=1.
REQ-018 i_pose_valid SHALL load all 12 words into the shadow register.
REQ-019 i_pose_commit SHALL copy the shadow register to the active register at the clock edge.
REQ-020 When i_pose_valid and i_pose_commit are high in the same cycle, the active register SHALL receive i_pose directly.
REQ-021 A point accepted in cycle N SHALL use the active pose and i_mode present after all updates up to cycle N-1.
REQ-022 Translation and mode SHALL travel with each point down the pipeline, so every output uses a single coherent pose.
REQ-023 A commit issued while points are in flight SHALL NOT alter those points.

Reset
REQ-024 Under i_rst: o_valid=0, all stage valids 0, o_cloud_*=0, o_sat=0.
REQ-025 Under i_rst, active and shadow pose SHALL be identity: R diagonal = 1<<MUL, off-diagonal 0, t=0.
REQ-026 Reset asserted mid-stream SHALL discard all in-flight points; o_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-027 CLOUD_BW, POSE_BW, MUL and a pose-array typedef SHALL reside in RgbdVoConfigPk.
REQ-028 One sub-module, mult_pipe2, SHALL provide a generic signed 2-stage multiplier with an enable (stall) input; it SHALL be instantiated 9 times.
REQ-029 No vendor multiplier IP SHALL be used.

Verification (bench: CLOUD_BW=16, POSE_BW=16, MUL=8)
REQ-030 Reset pose, p=(100,-200,300), i_ready=1 -> output (100,-200,300) exactly 3 cycles later, o_sat=0.
REQ-031 Pose R=90deg about z (R[0][1]=-256, R[1][0]=256, R[2][2]=256), t=(10,20,30), p=(5,7,9), mode 0 -> (3,25,39); mode 1 -> (-7,5,9).
REQ-032 R=diag(512), p=(30000,-30000,0) -> (32767,-32768,0), o_sat=3'b011.
REQ-033 Stream of 20 points with i_ready toggling pseudo-randomly -> all 20 outputs in order, values held while i_ready=0, o_ready low only when the output stage is full and i_ready=0.
REQ-034 Commit a new pose while 2 points are in flight, with simultaneous i_pose_valid and commit -> in-flight points use the old pose; the next accepted point uses the new i_pose.
REQ-035 Assert i_rst with 3 points in flight -> no o_valid afterwards; pose returns to identity.

Source files
------------

// File: rtl/pose_transform_stream_pkg.sv
// Shared configuration for the pose transform stream: widths and pose typedef.
// Pose words are row-major 3x4 [R|t]; rotation elements carry MUL fractional bits.
package RgbdVoConfigPk;

    localparam int CLOUD_BW = 16;
    localparam int POSE_BW  = 16;
    localparam int MUL      = 8;
    localparam int NPOSE    = 12;

    typedef logic [NPOSE-1:0][POSE_BW-1:0] pose_arr_t;

    // Rotation diagonal positions in the row-major 3x4 layout
    function automatic logic is_diag(input int k);
        return (k == 0) || (k == 5) || (k == 10);
    endfunction

endpackage

// File: rtl/pose_transform_stream_mult_pipe2.sv
// Generic signed two-stage multiplier with a shared stall enable.
// Ports: i_clk, i_en (advance), i_a/i_b operands, o_p full-precision product.
module mult_pipe2 #(
    parameter int AW = 16,
    parameter int BW = 16
) (
    input  logic                  i_clk,
    input  logic                  i_en,
    input  logic signed [AW-1:0]  i_a,
    input  logic signed [BW-1:0]  i_b,
    output logic signed [AW+BW-1:0] o_p
);

    logic signed [AW-1:0] a_q;
    logic signed [BW-1:0] b_q;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            a_q <= i_a;
            b_q <= i_b;
            o_p <= a_q * b_q;
        end
    end

endmodule

// File: rtl/pose_transform_stream.sv
// Streams 3D points through p' = sat(R*p [+ t]) in a 3-stage stall-able pipe.
// Ports: i_clk/i_rst, point in (i_valid/o_ready), pose load/commit, out (o_valid/i_ready).
module pose_transform_stream #(
    parameter int CLOUD_BW = RgbdVoConfigPk::CLOUD_BW,
    parameter int POSE_BW  = RgbdVoConfigPk::POSE_BW,
    parameter int MUL      = RgbdVoConfigPk::MUL
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic signed [CLOUD_BW-1:0] i_cloud_x,
    input  logic signed [CLOUD_BW-1:0] i_cloud_y,
    input  logic signed [CLOUD_BW-1:0] i_cloud_z,
    input  logic                       i_pose_valid,
    input  logic [11:0][POSE_BW-1:0]   i_pose,
    input  logic                       i_pose_commit,
    input  logic                       i_mode,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic signed [CLOUD_BW-1:0] o_cloud_x,
    output logic signed [CLOUD_BW-1:0] o_cloud_y,
    output logic signed [CLOUD_BW-1:0] o_cloud_z,
    output logic [2:0]                 o_sat
);

    import RgbdVoConfigPk::*;

    localparam int PW = CLOUD_BW + POSE_BW;
    localparam int HW = PW - MUL;
    localparam int SW = CLOUD_BW + POSE_BW - MUL + 2;

    localparam logic signed [SW-1:0] SMAX =
        {{(SW-CLOUD_BW+1){1'b0}}, {(CLOUD_BW-1){1'b1}}};
    localparam logic signed [SW-1:0] SMIN = ~SMAX;

    logic [NPOSE-1:0][POSE_BW-1:0] ident;
    logic [NPOSE-1:0][POSE_BW-1:0] shadow_q;
    logic [NPOSE-1:0][POSE_BW-1:0] active_q;

    logic                         advance;
    logic                         v1_q;
    logic                         v2_q;
    logic [2:0][POSE_BW-1:0]      t1_q;
    logic [2:0][POSE_BW-1:0]      t2_q;
    logic [2:0][CLOUD_BW-1:0]     pt;
    logic [2:0][2:0][PW-1:0]      prod;

    logic signed [PW-1:0]         pfull;
    logic signed [HW-1:0]         ptrunc;
    logic signed [SW-1:0]         acc [3];
    logic [2:0][CLOUD_BW-1:0]     res;
    logic [2:0]                   sat;

    always_comb begin
        ident = '0;
        for (int k = 0; k < NPOSE; k++) begin
            if (is_diag(k)) begin
                ident[k] = POSE_BW'(1 << MUL);
            end
        end
    end

    // Pose registers: shadow loads, commit publishes; a same-cycle
    // load+commit bypasses the shadow so the new words land at once.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shadow_q <= ident;
            active_q <= ident;
        end else begin
            if (i_pose_valid) begin
                shadow_q <= i_pose;
            end
            if (i_pose_commit) begin
                active_q <= i_pose_valid ? i_pose : shadow_q;
            end
        end
    end

    // Whole pipe moves in lockstep; only a full, unaccepted output stalls.
    assign advance = !o_valid || i_ready;
    assign o_ready = advance;

    assign pt = {i_cloud_z, i_cloud_y, i_cloud_x};

    // Translation and mode are resolved at acceptance and ride with the point.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            t1_q <= '0;
            t2_q <= '0;
        end else if (advance) begin
            v1_q <= i_valid;
            v2_q <= v1_q;
            t1_q <= i_mode ? '0 :
                    {active_q[11], active_q[7], active_q[3]};
            t2_q <= t1_q;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_row
        for (genvar j = 0; j < 3; j++) begin : g_col
            mult_pipe2 #(
                .AW(CLOUD_BW),
                .BW(POSE_BW)
            ) u_mul (
                .i_clk(i_clk),
                .i_en (advance),
                .i_a  (pt[j]),
                .i_b  (active_q[i*4+j]),
                .o_p  (prod[i][j])
            );
        end
    end

    always_comb begin
        pfull  = '0;
        ptrunc = '0;
        res    = '0;
        sat    = '0;
        for (int i = 0; i < 3; i++) begin
            acc[i] = SW'($signed(t2_q[i]));
            for (int j = 0; j < 3; j++) begin
                pfull  = $signed(prod[i][j]);
                ptrunc = HW'(pfull >>> MUL);
                acc[i] = acc[i] + SW'(ptrunc);
            end
            if (acc[i] > SMAX) begin
                res[i] = SMAX[CLOUD_BW-1:0];
                sat[i] = 1'b1;
            end else if (acc[i] < SMIN) begin
                res[i] = SMIN[CLOUD_BW-1:0];
                sat[i] = 1'b1;
            end else begin
                res[i] = acc[i][CLOUD_BW-1:0];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid   <= 1'b0;
            o_cloud_x <= '0;
            o_cloud_y <= '0;
            o_cloud_z <= '0;
            o_sat     <= '0;
        end else if (advance) begin
            o_valid <= v2_q;
            if (v2_q) begin
                o_cloud_x <= res[0];
                o_cloud_y <= res[1];
                o_cloud_z <= res[2];
                o_sat     <= sat;
            end
        end
    end

endmodule

// File: tb/tb_pose_transform_stream.sv
// Scoreboard bench for pose_transform_stream with a reference model.
// Ports: drives all DUT inputs; checks outputs, handshake and reset.
module tb_pose_transform_stream;

    import RgbdVoConfigPk::*;

    typedef struct packed {
        logic [2:0]  sat;
        logic [15:0] z;
        logic [15:0] y;
        logic [15:0] x;
    } res_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_valid;
    logic              o_ready;
    logic signed [15:0] cx, cy, cz;
    logic              pose_valid;
    pose_arr_t         pose_in;
    logic              commit;
    logic              mode;
    logic              o_valid;
    logic              i_ready;
    logic signed [15:0] ox, oy, oz;
    logic [2:0]        osat;

    pose_transform_stream #(
        .CLOUD_BW(16),
        .POSE_BW (16),
        .MUL     (8)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_cloud_x    (cx),
        .i_cloud_y    (cy),
        .i_cloud_z    (cz),
        .i_pose_valid (pose_valid),
        .i_pose       (pose_in),
        .i_pose_commit(commit),
        .i_mode       (mode),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_cloud_x    (ox),
        .o_cloud_y    (oy),
        .o_cloud_z    (oz),
        .o_sat        (osat)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    res_t exp_q[$];
    int   stamp_q[$];
    bit   lat_q[$];
    int   m_sh[12];
    int   m_act[12];
    int   cyc = 0;
    bit   prev_rst = 1'b1;
    bit   hold_v = 1'b0;
    res_t held;
    bit   lat_mode = 1'b0;
    bit   done = 1'b0;

    function automatic void ident(output int r[12]);
        for (int k = 0; k < 12; k++) r[k] = 0;
        r[0] = 256;
        r[5] = 256;
        r[10] = 256;
    endfunction

    function automatic res_t model(input int px, input int py, input int pz,
                                   input int r[12], input bit md);
        int     p[3];
        longint s;
        logic [15:0] v[3];
        res_t   o;
        p[0] = px;
        p[1] = py;
        p[2] = pz;
        o = '0;
        for (int i = 0; i < 3; i++) begin
            s = 0;
            for (int j = 0; j < 3; j++)
                s += (longint'(r[i*4+j]) * longint'(p[j])) >>> 8;
            if (!md) s += r[i*4+3];
            if (s > 32767) begin
                s = 32767;
                o.sat[i] = 1'b1;
            end else if (s < -32768) begin
                s = -32768;
                o.sat[i] = 1'b1;
            end
            v[i] = 16'(s);
        end
        o.x = v[0];
        o.y = v[1];
        o.z = v[2];
        return o;
    endfunction

    // Monitor + reference model, all at the falling edge.
    always @(negedge clk) begin
        res_t cur, e;
        int   st;
        bit   lf;
        cyc++;
        cur = {osat, oz, oy, ox};
        if (rst) begin
            exp_q.delete();
            stamp_q.delete();
            lat_q.delete();
            ident(m_sh);
            ident(m_act);
            hold_v = 1'b0;
        end else begin
            if (prev_rst) begin
                total++;
                if (o_valid !== 1'b0 || cur !== '0 || o_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL reset_state: got v=%b r=%b out=%h, want v=0 r=1 out=0",
                             o_valid, o_ready, cur);
                end
            end
            if (hold_v) begin
                total++;
                if (o_valid !== 1'b1 || cur !== held) begin
                    bad++;
                    $display("FAIL hold: got v=%b %h, want v=1 %h", o_valid, cur, held);
                end
            end
            hold_v = 1'b0;
            if (o_valid === 1'b1) begin
                if (i_ready) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_out: got %h, want no output", cur);
                    end else begin
                        e  = exp_q.pop_front();
                        st = stamp_q.pop_front();
                        lf = lat_q.pop_front();
                        if (cur !== e) begin
                            bad++;
                            $display("FAIL data: got sat=%b z=%0d y=%0d x=%0d, want sat=%b z=%0d y=%0d x=%0d",
                                     cur.sat, $signed(cur.z), $signed(cur.y), $signed(cur.x),
                                     e.sat, $signed(e.z), $signed(e.y), $signed(e.x));
                        end
                        if (lf) begin
                            total++;
                            if (cyc - st != 3) begin
                                bad++;
                                $display("FAIL latency: got %0d, want 3", cyc - st);
                            end
                        end
                    end
                end else begin
                    hold_v = 1'b1;
                    held = cur;
                end
            end
            total++;
            if (o_ready !== (!o_valid || i_ready)) begin
                bad++;
                $display("FAIL o_ready: got %b, want %b", o_ready, !o_valid || i_ready);
            end
            if (i_valid && o_ready) begin
                exp_q.push_back(model(cx, cy, cz, m_act, mode));
                stamp_q.push_back(cyc);
                lat_q.push_back(lat_mode);
            end
            if (commit) begin
                for (int k = 0; k < 12; k++)
                    m_act[k] = pose_valid ? int'($signed(pose_in[k])) : m_sh[k];
            end
            if (pose_valid) begin
                for (int k = 0; k < 12; k++)
                    m_sh[k] = int'($signed(pose_in[k]));
            end
        end
        prev_rst = rst;
        if (done) begin
            total++;
            if (exp_q.size() != 0) begin
                bad++;
                $display("FAIL drain: got %0d pending, want 0", exp_q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x, input int y, input int z, input bit md);
        bit acc;
        i_valid = 1'b1;
        cx = 16'(x);
        cy = 16'(y);
        cz = 16'(z);
        mode = md;
        for (int n = 0; n < 100; n++) begin
            #1;
            acc = o_ready;
            step();
            if (acc) break;
        end
        i_valid = 1'b0;
    endtask

    task automatic load_pose(input pose_arr_t p, input bit c);
        pose_in = p;
        pose_valid = 1'b1;
        commit = c;
        step();
        pose_valid = 1'b0;
        commit = 1'b0;
    endtask

    task automatic drain();
        i_ready = 1'b1;
        for (int n = 0; n < 60 && exp_q.size() != 0; n++) step();
        step();
    endtask

    function automatic pose_arr_t mk(input int r00, input int r01, input int r02, input int t0,
                                     input int r10, input int r11, input int r12, input int t1,
                                     input int r20, input int r21, input int r22, input int t2);
        pose_arr_t p;
        p[0] = 16'(r00); p[1] = 16'(r01); p[2]  = 16'(r02); p[3]  = 16'(t0);
        p[4] = 16'(r10); p[5] = 16'(r11); p[6]  = 16'(r12); p[7]  = 16'(t1);
        p[8] = 16'(r20); p[9] = 16'(r21); p[10] = 16'(r22); p[11] = 16'(t2);
        return p;
    endfunction

    initial begin
        pose_arr_t rp;
        int        got;
        rst = 1'b1;
        i_valid = 1'b0;
        cx = '0; cy = '0; cz = '0;
        pose_valid = 1'b0;
        pose_in = '0;
        commit = 1'b0;
        mode = 1'b0;
        i_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        lat_mode = 1'b1;
        send(100, -200, 300, 1'b0);
        drain();
        lat_mode = 1'b0;

        load_pose(mk(0, -256, 0, 10, 256, 0, 0, 20, 0, 0, 256, 30), 1'b1);
        send(5, 7, 9, 1'b0);
        send(5, 7, 9, 1'b1);
        drain();

        load_pose(mk(512, 0, 0, 0, 0, 512, 0, 0, 0, 0, 512, 0), 1'b0);
        pose_in = '0;
        commit = 1'b1;
        step();
        commit = 1'b0;
        send(30000, -30000, 0, 1'b0);
        send(-200, 100, 65, 1'b1);
        drain();

        send(11, 22, 33, 1'b0);
        send(-44, 55, -66, 1'b0);
        load_pose(mk(256, 0, 0, 1000, 0, 128, 0, -1000, 0, 0, -256, 7), 1'b1);
        send(400, 400, 400, 1'b0);
        drain();

        got = 0;
        for (int n = 0; n < 2000 && got < 20; n++) begin
            i_ready = 1'($urandom_range(0, 1));
            i_valid = ($urandom_range(0, 3) != 0);
            cx = 16'($urandom);
            cy = 16'($urandom);
            cz = 16'($urandom);
            mode = 1'($urandom_range(0, 1));
            pose_valid = ($urandom_range(0, 7) == 0);
            commit = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < 12; k++)
                rp[k] = ((k % 4) == 3) ? 16'($urandom)
                                       : 16'(int'($urandom_range(0, 1023)) - 512);
            pose_in = rp;
            #1;
            if (i_valid && o_ready) got++;
            step();
        end
        i_valid = 1'b0;
        pose_valid = 1'b0;
        commit = 1'b0;
        drain();

        load_pose(mk(0, 256, 0, 5, 256, 0, 0, 6, 0, 0, 256, 7), 1'b1);
        send(1, 2, 3, 1'b0);
        send(4, 5, 6, 1'b0);
        send(7, 8, 9, 1'b0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        repeat (6) step();
        send(123, -456, 789, 1'b0);
        drain();

        done = 1'b1;
        repeat (4) step();
        $display("FAIL end: got no summary, want summary");
        $fatal(1);
    end

endmodule
